// File: rtl/apb4_master_bridge.sv
// APB4 initiator: one valid/ready request -> SETUP/ACCESS, response 3 cycles after accept plus PREADY waits.
// One transfer in flight; request stalls outside IDLE; optional ACCESS timeout under APB4_MASTER_TIMEOUT_EN.
module apb4_master_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    req_write_i,
   input  logic [ADDR_WIDTH-1:0]   req_addr_i,
   input  logic [DATA_WIDTH-1:0]   req_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
   input  logic [2:0]              req_prot_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic [ADDR_WIDTH-1:0]   paddr_o,
   output logic [2:0]              pprot_o,
   output logic                    psel_o,
   output logic                    penable_o,
   output logic                    pwrite_o,
   output logic [DATA_WIDTH-1:0]   pwdata_o,
   output logic [DATA_WIDTH/8-1:0] pstrb_o,
   input  logic                    pready_i,
   input  logic [DATA_WIDTH-1:0]   prdata_i,
   input  logic                    pslverr_i
);

   localparam int STRB_W = DATA_WIDTH / 8;

   if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_data_width
      $error("apb4_master_bridge: DATA_WIDTH must be 8, 16 or 32");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb4_master_bridge: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
   logic [2:0]              pprot_q, pprot_d;
   logic                    psel_q, psel_d;
   logic                    penable_q, penable_d;
   logic                    pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
   logic [STRB_W-1:0]       pstrb_q, pstrb_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                    rsp_err_q, rsp_err_d;

`ifdef APB4_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]        tmo_q, tmo_d;
`endif

   always_comb begin
      state_d     = state_q;
      paddr_d     = paddr_q;
      pprot_d     = pprot_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      pstrb_d     = pstrb_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
`ifdef APB4_MASTER_TIMEOUT_EN
      tmo_d       = tmo_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               state_d   = SETUP;
               paddr_d   = req_addr_i;
               pprot_d   = req_prot_i;
               pwrite_d  = req_write_i;
               // Reads drive no write data and no strobes on the bus.
               pwdata_d  = req_write_i ? req_wdata_i : '0;
               pstrb_d   = req_write_i ? req_wstrb_i : '0;
               psel_d    = 1'b1;
               penable_d = 1'b0;
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
`ifdef APB4_MASTER_TIMEOUT_EN
            tmo_d     = '0;
`endif
         end
         ACCESS: begin
            if (pready_i) begin
               state_d     = RESP;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = pslverr_i;
               rsp_rdata_d = (!pwrite_q && !pslverr_i) ? prdata_i : '0;
            end
`ifdef APB4_MASTER_TIMEOUT_EN
            else if (tmo_q == CNT_W'(TIMEOUT_CYCLES)) begin
               state_d     = RESP;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         paddr_q     <= '0;
         pprot_q     <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
`ifdef APB4_MASTER_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         paddr_q     <= paddr_d;
         pprot_q     <= pprot_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         pstrb_q     <= pstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
`ifdef APB4_MASTER_TIMEOUT_EN
         tmo_q       <= tmo_d;
`endif
      end
   end

   assign req_ready_o = (state_q == IDLE) && !rst_i;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
   assign paddr_o     = paddr_q;
   assign pprot_o     = pprot_q;
   assign psel_o      = psel_q;
   assign penable_o   = penable_q;
   assign pwrite_o    = pwrite_q;
   assign pwdata_o    = pwdata_q;
   assign pstrb_o     = pstrb_q;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Scoreboard bench for apb4_master_bridge: directed transfers, an APB slave model and a response monitor.
module tb_apb4_master_bridge;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i, req_ready_o, req_write_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic [3:0]  req_wstrb_i;
   logic [2:0]  req_prot_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic [31:0] paddr_o, pwdata_o, prdata_i;
   logic [2:0]  pprot_o;
   logic        psel_o, penable_o, pwrite_o, pready_i, pslverr_i;
   logic [3:0]  pstrb_o;

   apb4_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
      .req_prot_i(req_prot_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o(rsp_err_o),
      .paddr_o(paddr_o), .pprot_o(pprot_o), .psel_o(psel_o), .penable_o(penable_o),
      .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
      .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [2:0]  prot;
      int          waits;
      logic [31:0] prdata;
      logic        slverr;
      int          acc;
   } apb_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          waits;
      int          stall;
      int          acc;
   } rsp_t;

   apb_t apb_q[$];
   rsp_t rsp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   last_hs_cyc = 0;
   int   last_acc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // APB slave model: drives PREADY after the transfer's wait count, checks bus fields and timing.
   apb_t cur;
   int   wcnt = 0;
   int   acnt = 0;

   task automatic chk_fields(input string ph);
      chk({ph, "_paddr"},  paddr_o,  cur.addr);
      chk({ph, "_pwrite"}, pwrite_o, cur.wr);
      chk({ph, "_pwdata"}, pwdata_o, cur.wdata);
      chk({ph, "_pstrb"},  pstrb_o,  cur.strb);
      chk({ph, "_pprot"},  pprot_o,  cur.prot);
   endtask

   always @(negedge clk_i) begin
      if (psel_o && !penable_o) begin
         pready_i = 1'b0;
         if (apb_q.size() == 0) begin
            chk("unexpected_setup", 1, 0);
         end else begin
            cur = apb_q[0];
            chk("setup_latency", cyc - cur.acc, 1);
            chk_fields("setup");
            wcnt = cur.waits;
            acnt = 0;
         end
      end else if (psel_o && penable_o) begin
         acnt++;
         if (acnt == 1) begin
            chk("access_latency", cyc - cur.acc, 2);
            chk_fields("access_first");
         end
         if (wcnt > 0) begin
            // Error and data are noise until PREADY; the bridge must ignore them.
            pready_i  = 1'b0;
            pslverr_i = 1'b1;
            prdata_i  = $urandom;
            wcnt--;
         end else begin
            pready_i  = 1'b1;
            pslverr_i = cur.slverr;
            prdata_i  = cur.prdata;
            chk_fields("access_last");
            chk("penable_cycles", acnt, cur.waits + 1);
            if (apb_q.size() > 0) void'(apb_q.pop_front());
         end
      end else begin
         pready_i  = 1'b0;
         pslverr_i = 1'b0;
      end
   end

   // Response monitor: pops the scoreboard when a response is presented.
   rsp_t rc;
   bit   seen = 1'b0;
   int   stall = 0;

   always @(negedge clk_i) begin
      if (rsp_valid_o) begin
         if (rsp_q.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
            rsp_ready_i = 1'b1;
         end else begin
            rc = rsp_q[0];
            if (!seen) begin
               chk("rsp_latency", cyc - rc.acc, 3 + rc.waits);
               seen  = 1'b1;
               stall = rc.stall;
            end
            chk("rsp_rdata", rsp_rdata_o, rc.rdata);
            chk("rsp_err", rsp_err_o, rc.err);
            chk("req_ready_in_resp", req_ready_o, 0);
            if (stall > 0) begin
               rsp_ready_i = 1'b0;
               stall--;
            end else begin
               rsp_ready_i = 1'b1;
               last_hs_cyc = cyc;
               void'(rsp_q.pop_front());
               seen = 1'b0;
            end
         end
      end else begin
         rsp_ready_i = 1'b1;
      end
   end

   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input int waits,
                        input logic [31:0] prd, input logic err, input int stl);
      apb_t a;
      rsp_t r;
      int   b = 0;
      @(negedge clk_i);
      req_valid_i = 1'b1;
      req_write_i = wr;
      req_addr_i  = addr;
      req_wdata_i = wdata;
      req_wstrb_i = strb;
      req_prot_i  = prot;
      while (!req_ready_o && b < 2000) begin
         @(negedge clk_i);
         b++;
      end
      if (!req_ready_o) begin
         chk("accept_timeout", 0, 1);
         req_valid_i = 1'b0;
         return;
      end
      a.wr = wr; a.addr = addr; a.prot = prot; a.waits = waits;
      a.wdata = wr ? wdata : 32'h0;
      a.strb  = wr ? strb : 4'h0;
      a.prdata = prd; a.slverr = err; a.acc = cyc;
      apb_q.push_back(a);
      r.rdata = (wr || err) ? 32'h0 : prd;
      r.err = err; r.waits = waits; r.stall = stl; r.acc = cyc;
      rsp_q.push_back(r);
      last_acc = cyc;
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      rst_i = 1'b1;
      req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
      req_wstrb_i = '0; req_prot_i = '0;
      rsp_ready_i = 1'b1; pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0;

      repeat (2) @(negedge clk_i);
      chk("reset_psel", psel_o, 0);
      chk("reset_penable", penable_o, 0);
      chk("reset_paddr", paddr_o, 0);
      chk("reset_pwdata", pwdata_o, 0);
      chk("reset_pstrb_pprot_pwrite", {pstrb_o, pprot_o, pwrite_o}, 0);
      chk("reset_rsp", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, 0);
      chk("reset_req_ready", req_ready_o, 0);
      rst_i = 1'b0;
      #1 chk("post_reset_req_ready", req_ready_o, 1);

      issue(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 32'hCAFE_F00D, 1'b0, 0);
      issue(1'b0, 32'h0000_0008, 32'h1111_2222, 4'hF, 3'b010, 3, 32'h1234_5678, 1'b0, 0);
      issue(1'b0, 32'h0000_000C, 32'h0, 4'h0, 3'b000, 1, 32'hAAAA_5555, 1'b1, 0);
      issue(1'b1, 32'h0000_001C, 32'h0000_BEEF, 4'h3, 3'b101, 2, 32'h7777_7777, 1'b1, 0);

      // Response held off for 5 cycles while the next request waits.
      issue(1'b1, 32'h0000_0010, 32'h55AA_55AA, 4'hF, 3'b000, 0, 32'h0, 1'b0, 5);
      issue(1'b0, 32'h0000_0014, 32'h0, 4'h0, 3'b001, 0, 32'h0BAD_CAFE, 1'b0, 0);
      chk("accept_after_rsp_handshake", last_acc - last_hs_cyc, 1);

      // Reset in the middle of ACCESS drops the transfer with no response.
      issue(1'b0, 32'h0000_0018, 32'h0, 4'h0, 3'b000, 20, 32'h9999_9999, 1'b0, 0);
      @(negedge clk_i);
      @(negedge clk_i);
      chk("pre_reset_in_access", {psel_o, penable_o}, 2'b11);
      rst_i = 1'b1;
      void'(apb_q.pop_back());
      void'(rsp_q.pop_back());
      @(negedge clk_i);
      chk("midrst_psel", psel_o, 0);
      chk("midrst_penable", penable_o, 0);
      chk("midrst_rsp_valid", rsp_valid_o, 0);
      rst_i = 1'b0;
      #1 chk("midrst_req_ready", req_ready_o, 1);

      issue(1'b1, 32'h0000_0020, 32'h0102_0304, 4'h5, 3'b000, 0, 32'h0, 1'b0, 0);

      // Without the timeout feature a stalled ACCESS never aborts.
      issue(1'b0, 32'h0000_0024, 32'h0, 4'h0, 3'b000, 1100, 32'h600D_F00D, 1'b0, 0);
      repeat (1000) @(negedge clk_i);
      chk("pending_psel", psel_o, 1);
      chk("pending_penable", penable_o, 1);
      chk("pending_rsp_valid", rsp_valid_o, 0);

      b = 0;
      while ((apb_q.size() != 0 || rsp_q.size() != 0 || rsp_valid_o) && b < 1500) begin
         @(negedge clk_i);
         b++;
      end
      chk("drain_apb_q", apb_q.size(), 0);
      chk("drain_rsp_q", rsp_q.size(), 0);
      repeat (3) @(negedge clk_i);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
